fifo_unpack: RTL and testbench
==============================

# fifo_unpack

Read-side stage placed directly downstream of the team's `fifo` primitive. It pops DATA_WIDTH-bit words from the FIFO using a one-cycle-latency read interface. It splits each word into RATIO = DATA_WIDTH/OUT_WIDTH narrower chunks and presents them on a valid/ready stream. Two words of internal buffering are enough to sustain one chunk per cycle with no bubbles between words.

## Interface
- DATA_WIDTH, 32, FIFO word width. Must be an integer multiple of OUT_WIDTH, with RATIO ≥ 2.
- OUT_WIDTH, 8, output chunk width.
- LSB_FIRST, 1, chunk order. 1 means bits [OUT_WIDTH-1:0] are emitted first; 0 means the MS chunk is emitted first.
- clk  input  1  sole clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  pop request. fifo_data is valid in the cycle after this is high.
- fifo_data  input  DATA_WIDTH  FIFO read data.
- out_data  output  OUT_WIDTH  current chunk.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the chunk.
- out_last  output  1  current chunk is the final chunk of its word.
- busy  output  1  a word is held, prefetched, or in flight.

## Operation
- State:
  - hold_word/hold_valid: the word being emitted.
  - pre_word/pre_valid: the prefetched word.
  - rd_pend: a read was issued last cycle.
  - idx: chunk index, $clog2(RATIO) bits.
- Derived signals:
  - occ = hold_valid + pre_valid + rd_pend (range 0..2).
  - fire = out_valid & out_ready.
  - word_done = fire & (idx == RATIO-1).
- fifo_rd_en = rst & ~fifo_empty & (occ < 2 | (occ == 2 & word_done)). It is never asserted while fifo_empty=1, so there is no underflow. rd_pend <= fifo_rd_en.
- Capture (when rd_pend=1, fifo_data is sampled):
  - It goes to hold if hold is empty, or if word_done this cycle and pre is empty.
  - Otherwise it goes to pre.
  - A word never overwrites a valid, unconsumed slot.
- On word_done:
  - If pre_valid, pre moves to hold and pre_valid clears.
  - Otherwise, if a capture is occurring, the captured word goes to hold.
  - Otherwise hold_valid clears.
  - idx wraps to 0.
- On fire without word_done: idx increments.
- Simultaneous word_done, capture and pre_valid: pre moves to hold and the capture goes to pre.
- out_valid = hold_valid.
- out_data = chunk idx of hold_word:
  - LSB_FIRST=1: hold_word[idx*OUT_WIDTH +: OUT_WIDTH].
  - LSB_FIRST=0: chunk (RATIO-1-idx).
- out_last = hold_valid & (idx == RATIO-1).
- busy = (occ != 0).
- While out_valid=1 and out_ready=0, out_data and out_last remain stable.
- Reset (rst low, asynchronous):
  - All state clears: hold/pre words 0, valids 0, rd_pend 0, idx 0.
  - Outputs: out_valid 0, out_data 0, out_last 0, busy 0, fifo_rd_en 0.
  - In-flight reads are discarded. Any words already popped are lost; the FIFO is reset in the same domain.
- Reset deassertion is synchronised externally. The first rd_en may occur in the first cycle after release.

## Timing
- Cycle N: fifo_rd_en=1. Cycle N+1: fifo_data is valid and captured at the edge ending N+1. Cycle N+2: out_valid=1 with chunk 0.
- First-chunk latency is 2 cycles from rd_en, or 2 cycles from the fifo_empty fall when the block is idle.
- Sustained throughput with out_ready held at 1 and the FIFO non-empty is one chunk per cycle, with no gap between words, for any RATIO ≥ 2.
- A word is popped from the FIFO at most every cycle, and on average once per RATIO cycles under full flow.
- No combinational path from out_ready to out_valid/out_data.
- There is a combinational path from fifo_empty and out_ready to fifo_rd_en only.

## Test plan
- Reset: assert rst=0 mid-stream (word 2 of 4, idx=1). Required: out_valid, out_last, busy and fifo_rd_en are 0 within the same cycle, out_data=0, and the stream restarts cleanly with the next FIFO word after release.
- Single word, LSB_FIRST=1, 32/8: FIFO holds 0xDDCCBBAA and out_ready=1. Required: rd_en is high for 1 cycle, then 2 cycles later AA, BB, CC, DD appear on consecutive cycles, with out_last=1 only on DD. busy falls after DD.
- Streaming: 4 words 0x03020100..0x0F0E0D0C preloaded, out_ready=1. Required: 16 consecutive valid cycles carrying bytes 0x00..0x0F in order, with no bubble and exactly 4 rd_en pulses.
- Backpressure: out_ready=0 for 5 cycles at idx=2, plus random ready afterwards. Required: out_data stays held at the idx-2 chunk, there are no extra pops beyond occ=2, and the byte order is intact.
- Empty handling: a word arrives in the FIFO every 7 cycles. Required: fifo_rd_en is never high while fifo_empty=1, and out_valid drops between words.
- LSB_FIRST=0, DATA_WIDTH=16, OUT_WIDTH=4: word 0xABCD. Required: output A, B, C, D, with out_last on D.

Source files
------------

// File: rtl/fifo_unpack_if.sv
// fifo_unpack_if: bundles the FIFO read port and the narrow output stream
// of the unpacker. master = the unpacker, slave = FIFO/consumer side.
interface fifo_unpack_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd_en, out_data, out_valid, out_last, busy
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/fifo_unpack.sv
// fifo_unpack: pops DATA_WIDTH words from a one-cycle-latency FIFO read
// port and streams them as RATIO chunks of OUT_WIDTH bits on valid/ready.
// A hold slot (word being emitted) plus a prefetch slot keep the output
// busy every cycle across word boundaries.
module fifo_unpack #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input logic           clk,
  input logic           rst,
  fifo_unpack_if.master bus
);
  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [DATA_WIDTH-1:0] hold_word_r;
  logic [DATA_WIDTH-1:0] pre_word_r;
  logic                  hold_valid_r;
  logic                  pre_valid_r;
  logic                  rd_pend_r;
  logic [IDX_W-1:0]      idx_r;

  logic [1:0]            occ_s;
  logic                  fire_s;
  logic                  word_done_s;
  logic                  rd_en_s;
  logic [IDX_W-1:0]      chunk_sel_s;
  logic [OUT_WIDTH-1:0]  out_data_s;

  // Occupancy, handshake and pop decision. A pop is allowed while fewer
  // than two words are owned, or at exactly two when one retires now.
  always_comb begin
    occ_s       = {1'b0, hold_valid_r} + {1'b0, pre_valid_r} + {1'b0, rd_pend_r};
    fire_s      = hold_valid_r & bus.out_ready;
    word_done_s = fire_s & (idx_r == IDX_LAST);
    if (rst && !bus.fifo_empty) begin
      rd_en_s = (occ_s < 2'd2) | ((occ_s == 2'd2) & word_done_s);
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Chunk selection: map the emission index onto the physical chunk.
  always_comb begin
    if (LSB_FIRST) begin
      chunk_sel_s = idx_r;
    end else begin
      chunk_sel_s = IDX_LAST - idx_r;
    end
    out_data_s = {OUT_WIDTH{1'b0}};
    for (int k = 0; k < RATIO; k++) begin
      if (chunk_sel_s == IDX_W'(k)) begin
        out_data_s = hold_word_r[k*OUT_WIDTH +: OUT_WIDTH];
      end else begin
        out_data_s = out_data_s;
      end
    end
  end

  // Output drive: everything except the pop request comes straight from state.
  always_comb begin
    bus.fifo_rd_en = rd_en_s;
    bus.out_valid  = hold_valid_r;
    bus.out_data   = out_data_s;
    bus.out_last   = hold_valid_r & (idx_r == IDX_LAST);
    bus.busy       = (occ_s != 2'd0);
  end

  // Word slots, read-pending flag and chunk index. Read data is captured
  // the cycle after the pop; it never lands on a valid, unconsumed slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_word_r  <= {DATA_WIDTH{1'b0}};
      pre_word_r   <= {DATA_WIDTH{1'b0}};
      hold_valid_r <= 1'b0;
      pre_valid_r  <= 1'b0;
      rd_pend_r    <= 1'b0;
      idx_r        <= {IDX_W{1'b0}};
    end else begin
      rd_pend_r <= rd_en_s;
      if (word_done_s) begin
        idx_r <= {IDX_W{1'b0}};
        if (pre_valid_r) begin
          // Prefetched word advances; a concurrent capture refills prefetch.
          hold_word_r <= pre_word_r;
          if (rd_pend_r) begin
            pre_word_r <= bus.fifo_data;
          end else begin
            pre_valid_r <= 1'b0;
          end
        end else if (rd_pend_r) begin
          hold_word_r <= bus.fifo_data;
        end else begin
          hold_valid_r <= 1'b0;
        end
      end else begin
        if (fire_s) begin
          idx_r <= idx_r + IDX_ONE;
        end else begin
          idx_r <= idx_r;
        end
        if (rd_pend_r) begin
          if (!hold_valid_r) begin
            hold_word_r  <= bus.fifo_data;
            hold_valid_r <= 1'b1;
          end else begin
            pre_word_r  <= bus.fifo_data;
            pre_valid_r <= 1'b1;
          end
        end else begin
          pre_valid_r <= pre_valid_r;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_unpack.sv
// tb_fifo_unpack: directed bench for fifo_unpack in two configurations
// (32/8 LSB first and 16/4 MS chunk first). A queue-based FIFO model feeds
// each instance; an expected-chunk queue built from the pushed words is
// compared against the output stream on every cycle.
module tb_fifo_unpack;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp observed events.
  always @(posedge clk) cyc <= cyc + 1;

  fifo_unpack_if #(.DATA_WIDTH(32), .OUT_WIDTH(8)) b0 ();
  fifo_unpack_if #(.DATA_WIDTH(16), .OUT_WIDTH(4)) b1 ();

  fifo_unpack #(.DATA_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .bus(b0.master));
  fifo_unpack #(.DATA_WIDTH(16), .OUT_WIDTH(4), .LSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .bus(b1.master));

  // FIFO contents, expected chunk streams {last, data}, owned-word counts
  logic [31:0] q0[$];
  logic [8:0]  e0[$];
  int          pend0 = 0;
  logic [7:0]  fd0[$];
  int          fc0[$];
  int          rc0[$];
  logic [15:0] q1[$];
  logic [4:0]  e1[$];
  int          pend1 = 0;
  logic [3:0]  fd1[$];
  logic        fl1[$];
  int          rc1[$];
  logic [8:0]  x0;
  logic [4:0]  x1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push a word into FIFO 0 and append its chunks, LS chunk first.
  task automatic push0(input logic [31:0] w);
    q0.push_back(w);
    for (int k = 0; k < 4; k++) e0.push_back({(k == 3) ? 1'b1 : 1'b0, w[8*k +: 8]});
  endtask

  // Push a word into FIFO 1 and append its chunks, MS chunk first.
  task automatic push1(input logic [15:0] w);
    q1.push_back(w);
    for (int k = 0; k < 4; k++) e1.push_back({(k == 3) ? 1'b1 : 1'b0, w[4*(3-k) +: 4]});
  endtask

  task automatic drain0(input int budget);
    for (int i = 0; i < budget && (e0.size() != 0 || b0.busy); i++) tick();
    check("drain0_timeout", e0.size(), 0);
  endtask

  task automatic drain1(input int budget);
    for (int i = 0; i < budget && (e1.size() != 0 || b1.busy); i++) tick();
    check("drain1_timeout", e1.size(), 0);
  endtask

  task automatic clear_logs();
    fd0.delete(); fc0.delete(); rc0.delete();
    fd1.delete(); fl1.delete(); rc1.delete();
  endtask

  // FIFO read-port models: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (b0.fifo_rd_en && q0.size() != 0) b0.fifo_data <= q0.pop_front();
    b0.fifo_empty <= (q0.size() == 0);
    if (b1.fifo_rd_en && q1.size() != 0) b1.fifo_data <= q1.pop_front();
    b1.fifo_empty <= (q1.size() == 0);
  end

  // Per-cycle comparison of instance 0 against the expected stream.
  always @(negedge clk) begin
    if (rst) begin
      check("rd_en_while_empty0", b0.fifo_rd_en & b0.fifo_empty, 0);
      check("busy0", b0.busy, pend0 != 0);
      check("occ_bound0", pend0 <= 2, 1);
      if (b0.out_valid) begin
        check("spurious_valid0", e0.size() != 0, 1);
        if (e0.size() != 0) begin
          x0 = e0[0];
          check("data0", b0.out_data, x0[7:0]);
          check("last0", b0.out_last, x0[8]);
          if (b0.out_ready) begin
            void'(e0.pop_front());
            fd0.push_back(b0.out_data);
            fc0.push_back(cyc);
            if (x0[8]) pend0--;
          end
        end
      end else begin
        check("last_idle0", b0.out_last, 0);
      end
      if (b0.fifo_rd_en) begin
        pend0++;
        rc0.push_back(cyc);
      end
    end
  end

  // Per-cycle comparison of instance 1 against the expected stream.
  always @(negedge clk) begin
    if (rst) begin
      check("rd_en_while_empty1", b1.fifo_rd_en & b1.fifo_empty, 0);
      check("busy1", b1.busy, pend1 != 0);
      if (b1.out_valid) begin
        check("spurious_valid1", e1.size() != 0, 1);
        if (e1.size() != 0) begin
          x1 = e1[0];
          check("data1", b1.out_data, x1[3:0]);
          check("last1", b1.out_last, x1[4]);
          if (b1.out_ready) begin
            void'(e1.pop_front());
            fd1.push_back(b1.out_data);
            fl1.push_back(b1.out_last);
            if (x1[4]) pend1--;
          end
        end
      end else begin
        check("last_idle1", b1.out_last, 0);
      end
      if (b1.fifo_rd_en) begin
        pend1++;
        rc1.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] single_exp [4];
    logic [3:0] nib_exp [4];
    int found;
    single_exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    nib_exp    = '{4'hA, 4'hB, 4'hC, 4'hD};

    // Reset state
    b0.out_ready = 1'b0;
    b1.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid0", b0.out_valid, 0);
    check("rst_data0", b0.out_data, 0);
    check("rst_last0", b0.out_last, 0);
    check("rst_busy0", b0.busy, 0);
    check("rst_rd_en0", b0.fifo_rd_en, 0);
    check("rst_valid1", b1.out_valid, 0);
    rst = 1'b1;
    tick();

    // Single word, LSB first
    clear_logs();
    b0.out_ready = 1'b1;
    push0(32'hDDCCBBAA);
    drain0(30);
    check("single_rd_pulses", rc0.size(), 1);
    check("single_count", fd0.size(), 4);
    check("single_busy_end", b0.busy, 0);
    if (fd0.size() == 4 && rc0.size() == 1) begin
      for (int k = 0; k < 4; k++) begin
        check("single_byte", fd0[k], single_exp[k]);
        check("single_cycle", fc0[k], rc0[0] + 2 + k);
      end
    end

    // Streaming, four preloaded words
    clear_logs();
    push0(32'h03020100); push0(32'h07060504);
    push0(32'h0B0A0908); push0(32'h0F0E0D0C);
    drain0(60);
    check("stream_rd_pulses", rc0.size(), 4);
    check("stream_count", fd0.size(), 16);
    if (fd0.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check("stream_byte", fd0[i], i);
        check("stream_no_bubble", fc0[i], fc0[0] + i);
      end
    end

    // Backpressure at idx 2, then random ready
    clear_logs();
    push0(32'h13121110); push0(32'h17161514); push0(32'h1B1A1918);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (b0.out_valid && b0.out_data == 8'h12) found = 1;
    end
    check("bp_reach_idx2", found, 1);
    b0.out_ready = 1'b0;
    repeat (5) begin
      tick();
      check("bp_hold_data", b0.out_data, 8'h12);
      check("bp_hold_last", b0.out_last, 0);
    end
    check("bp_pops", rc0.size(), 2);
    for (int i = 0; i < 200 && e0.size() != 0; i++) begin
      b0.out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    b0.out_ready = 1'b1;
    drain0(30);
    check("bp_count", fd0.size(), 12);
    if (fd0.size() == 12) begin
      for (int i = 0; i < 12; i++) check("bp_byte", fd0[i], 8'h10 + i);
    end

    // Empty handling: one word every 7 cycles
    clear_logs();
    for (int w = 0; w < 4; w++) begin
      push0(32'h43424140 + 32'h04040404 * w);
      repeat (7) tick();
    end
    drain0(30);
    check("empty_count", fd0.size(), 16);
    check("empty_rd_pulses", rc0.size(), 4);
    if (fd0.size() == 16) begin
      for (int i = 0; i < 16; i++) check("empty_byte", fd0[i], 8'h40 + i);
      check("empty_gap", fc0[4] - fc0[3], 4);
    end

    // Reset mid-stream at word 2, idx 1
    clear_logs();
    push0(32'h23222120); push0(32'h27262524);
    push0(32'h2B2A2928); push0(32'h2F2E2D2C);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      tick();
      if (b0.out_valid && b0.out_data == 8'h25) found = 1;
    end
    check("mid_reach", found, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", b0.out_valid, 0);
    check("mid_rst_last", b0.out_last, 0);
    check("mid_rst_busy", b0.busy, 0);
    check("mid_rst_rd_en", b0.fifo_rd_en, 0);
    check("mid_rst_data", b0.out_data, 0);
    q0.delete(); e0.delete(); pend0 = 0;
    q1.delete(); e1.delete(); pend1 = 0;
    tick();
    tick();
    rst = 1'b1;
    clear_logs();
    push0(32'h33323130);
    drain0(30);
    check("restart_rd_pulses", rc0.size(), 1);
    check("restart_count", fd0.size(), 4);
    if (fd0.size() == 4 && rc0.size() == 1) begin
      for (int k = 0; k < 4; k++) check("restart_byte", fd0[k], 8'h30 + k);
      check("restart_latency", fc0[0], rc0[0] + 2);
    end

    // MS chunk first, 16/4
    clear_logs();
    b1.out_ready = 1'b1;
    push1(16'hABCD);
    drain1(30);
    check("msb_rd_pulses", rc1.size(), 1);
    check("msb_count", fd1.size(), 4);
    if (fd1.size() == 4) begin
      for (int k = 0; k < 4; k++) check("msb_nibble", fd1[k], nib_exp[k]);
      check("msb_last_first", fl1[0], 0);
      check("msb_last_final", fl1[3], 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
